// File: rtl/part_74s373_pkg.sv
// part_74s373_pkg: shared constants for the 74S373 octal transparent latch.
//   PART_74S373_WIDTH     - data width (eight bits, one port per bit at the top)
//   PART_74S373_RESET_VAL - value of the stored byte and outputs while reset is high
//   PART_74S373_IDLE_VAL  - value driven by disabled outputs when the
//                           PART_74S373_TRISTATE_EN macro is not defined
package part_74s373_pkg;
  localparam int PART_74S373_WIDTH = 8;
  localparam logic [PART_74S373_WIDTH-1:0] PART_74S373_RESET_VAL = 8'h00;
  localparam logic [PART_74S373_WIDTH-1:0] PART_74S373_IDLE_VAL  = 8'hFF;
endpackage

// File: rtl/part_74s373_if.sv
// part_74s373_if: byte-wide bundle of the latch pins.
//   i      - data inputs, bit 0 is I0 (LSB)
//   oenb_n - output enable, active-low
//   hold_n - latch control, 1 = transparent, 0 = hold
//   o      - data outputs, bit 0 is O0 (LSB)
// There is no handshake: the part is level-sensitive on hold_n/oenb_n and
// samples i on every rising clk edge at which hold_n is 1.
// master drives the inputs and observes o; slave is the latch side.
interface part_74s373_if;
  import part_74s373_pkg::*;

  logic [PART_74S373_WIDTH-1:0] i;
  logic                         oenb_n;
  logic                         hold_n;
  logic [PART_74S373_WIDTH-1:0] o;

  modport master (output i, output oenb_n, output hold_n, input  o);
  modport slave  (input  i, input  oenb_n, input  hold_n, output o);
endinterface

// File: rtl/part_74s373_bit.sv
// part_74s373_bit: one bit of the octal latch.
//   clk    - system clock, stored bit updates on the rising edge
//   reset  - asynchronous active-high reset, clears the stored bit and output
//   oenb_n - output enable, active-low
//   hold_n - 1 = transparent (output follows d_i), 0 = output shows stored bit
//   d_i    - data input bit
//   o      - data output bit
// Build option PART_74S373_TRISTATE_EN: disabled output floats (1'bz);
// otherwise the disabled output drives IDLE_BIT.
module part_74s373_bit
  import part_74s373_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0,
  parameter logic IDLE_BIT  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic oenb_n,
  input  logic hold_n,
  input  logic d_i,
  output logic o
);

  logic q_q;
  logic q_d;
  logic d_sel;

  // Capture while transparent, otherwise keep the stored bit.
  always_comb begin
    q_d = q_q;
    if (hold_n) q_d = d_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= RESET_BIT;
    else       q_q <= q_d;
  end

  // Reset overrides transparency so the outputs are defined during reset
  // even while hold_n is high. X/Z on d_i passes straight through.
  always_comb begin
    d_sel = hold_n ? d_i : q_q;
    if (reset) d_sel = RESET_BIT;
  end

  // oenb_n only gates the driver; it never touches the stored bit.
`ifdef PART_74S373_TRISTATE_EN
  assign o = oenb_n ? 1'bz : d_sel;
`else
  assign o = oenb_n ? IDLE_BIT : d_sel;
`endif

endmodule

// File: rtl/part_74s373.sv
// part_74s373: octal transparent latch with three-state outputs (74S373).
//   clk        - system clock, stored byte updates on the rising edge
//   reset      - asynchronous active-high reset, stored byte and outputs to 0
//   OENB_N     - output enable, active-low (1 = outputs disabled)
//   HOLD_N     - latch control (1 = transparent, 0 = hold)
//   I0..I7     - data inputs, I0 is the LSB
//   O0..O7     - data outputs, O0 is the LSB
// Build option PART_74S373_TRISTATE_EN: disabled outputs are 1'bz; when not
// defined they drive 8'hFF to emulate a pulled-up bus.
// This level only packs the pins into a byte bus and fans out to eight cells.
module part_74s373
  import part_74s373_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic OENB_N,
  input  logic HOLD_N,
  input  logic I0,
  input  logic I1,
  input  logic I2,
  input  logic I3,
  input  logic I4,
  input  logic I5,
  input  logic I6,
  input  logic I7,
  output logic O0,
  output logic O1,
  output logic O2,
  output logic O3,
  output logic O4,
  output logic O5,
  output logic O6,
  output logic O7
);

  part_74s373_if bus_if ();

  logic [PART_74S373_WIDTH-1:0] o_vec;

  assign bus_if.i      = {I7, I6, I5, I4, I3, I2, I1, I0};
  assign bus_if.oenb_n = OENB_N;
  assign bus_if.hold_n = HOLD_N;
  assign bus_if.o      = o_vec;

  for (genvar k = 0; k < PART_74S373_WIDTH; k++) begin : g_bit
    part_74s373_bit #(
      .RESET_BIT (PART_74S373_RESET_VAL[k]),
      .IDLE_BIT  (PART_74S373_IDLE_VAL[k])
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .oenb_n (bus_if.oenb_n),
      .hold_n (bus_if.hold_n),
      .d_i    (bus_if.i[k]),
      .o      (o_vec[k])
    );
  end

  assign {O7, O6, O5, O4, O3, O2, O1, O0} = bus_if.o;

endmodule

// File: tb/tb_part_74s373.sv
// tb_part_74s373: self-checking bench for part_74s373.
// Inputs change half a cycle away from the rising edge; outputs are sampled
// 1 time unit after each input change. The reference model keeps the held
// byte as a plain variable updated from the documented rules.
module tb_part_74s373;
  import part_74s373_pkg::*;

`ifdef PART_74S373_TRISTATE_EN
  localparam logic [7:0] EXP_IDLE = 8'hzz;
`else
  localparam logic [7:0] EXP_IDLE = PART_74S373_IDLE_VAL;
`endif

  logic       clk;
  logic       reset;
  wire  [7:0] o_w;
  int         tests_run;
  int         tests_failed;
  logic [7:0] m_held;          // model of the stored byte
  logic [7:0] exp_q[$];

  part_74s373_if bus ();

  part_74s373 dut (
    .clk    (clk),
    .reset  (reset),
    .OENB_N (bus.oenb_n),
    .HOLD_N (bus.hold_n),
    .I0 (bus.i[0]), .I1 (bus.i[1]), .I2 (bus.i[2]), .I3 (bus.i[3]),
    .I4 (bus.i[4]), .I5 (bus.i[5]), .I6 (bus.i[6]), .I7 (bus.i[7]),
    .O0 (o_w[0]), .O1 (o_w[1]), .O2 (o_w[2]), .O3 (o_w[3]),
    .O4 (o_w[4]), .O5 (o_w[5]), .O6 (o_w[6]), .O7 (o_w[7])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_out(input logic rst, input logic hold,
                                           input logic oen_n, input logic [7:0] din,
                                           input logic [7:0] held);
    logic [7:0] d;
    if (rst)       d = 8'h00;
    else if (hold) d = din;
    else           d = held;
    return oen_n ? EXP_IDLE : d;
  endfunction

  // One rising edge, with the model capturing alongside the DUT, then move
  // to the falling edge so the caller drives inputs away from the active edge.
  task automatic tick();
    @(posedge clk);
    if (reset)            m_held = 8'h00;
    else if (bus.hold_n)  m_held = bus.i;
    @(negedge clk);
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset = 1'b1; bus.i = 8'h00; bus.oenb_n = 1'b1; bus.hold_n = 1'b0;
    m_held = 8'h00;
    tick();
    #1;
    tests_run++;
    if (o_w !== EXP_IDLE) begin
      tests_failed++;
      $display("FAIL reset_disabled: got %h expected %h", o_w, EXP_IDLE);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_enable_after_reset();
    bus.oenb_n = 1'b0; bus.hold_n = 1'b0;
    #1;
    tests_run++;
    if (o_w !== 8'h00) begin
      tests_failed++;
      $display("FAIL enable_after_reset: got %h expected 00", o_w);
    end
    bus.i = 8'hA5;
    #1;
    tests_run++;
    if (o_w !== 8'h00) begin
      tests_failed++;
      $display("FAIL enable_input_toggle: got %h expected 00", o_w);
    end
    tick();
    #1;
    tests_run++;
    if (o_w !== 8'h00) begin
      tests_failed++;
      $display("FAIL enable_after_edge: got %h expected 00", o_w);
    end
  endtask

  task automatic test_transparent();
    bus.oenb_n = 1'b0; bus.hold_n = 1'b1; bus.i = 8'h00;
    #1;
    bus.i[0] = 1'b1;
    #1;
    tests_run++;
    if (o_w[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL transparent_rise: got O0=%b expected 1", o_w[0]);
    end
    bus.i[0] = 1'b0;
    #1;
    tests_run++;
    if (o_w[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL transparent_fall: got O0=%b expected 0", o_w[0]);
    end
    bus.i = 8'h5A;
    #1;
    tests_run++;
    if (o_w !== 8'h5A) begin
      tests_failed++;
      $display("FAIL transparent_byte: got %h expected 5a", o_w);
    end
    tick();
  endtask

  task automatic test_hold();
    bus.oenb_n = 1'b0; bus.hold_n = 1'b1; bus.i = 8'h01;
    tick();
    bus.hold_n = 1'b0;
    #1;
    bus.i = 8'h00;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests_run++;
      if (o_w !== 8'h01) begin
        tests_failed++;
        $display("FAIL hold_cycle%0d: got %h expected 01", c, o_w);
      end
      tick();
    end
  endtask

  task automatic test_disable_while_holding();
    bus.oenb_n = 1'b1;
    #1;
    tests_run++;
    if (o_w !== EXP_IDLE) begin
      tests_failed++;
      $display("FAIL disable_hold: got %h expected %h", o_w, EXP_IDLE);
    end
    tick();
    bus.oenb_n = 1'b0;
    #1;
    tests_run++;
    if (o_w !== 8'h01) begin
      tests_failed++;
      $display("FAIL reenable_hold: got %h expected 01", o_w);
    end
  endtask

  task automatic test_reset_mid_hold();
    bus.oenb_n = 1'b0; bus.hold_n = 1'b1; bus.i = 8'h3C;
    tick();
    bus.hold_n = 1'b0; bus.i = 8'hFF;
    #1;
    tests_run++;
    if (o_w !== 8'h3C) begin
      tests_failed++;
      $display("FAIL mid_hold_loaded: got %h expected 3c", o_w);
    end
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if (o_w !== 8'h00) begin
      tests_failed++;
      $display("FAIL mid_hold_reset: got %h expected 00", o_w);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests_run++;
      if (o_w !== 8'h00) begin
        tests_failed++;
        $display("FAIL after_reset_hold%0d: got %h expected 00", c, o_w);
      end
      tick();
    end
    bus.hold_n = 1'b1;
    #1;
    tests_run++;
    if (o_w !== 8'hFF) begin
      tests_failed++;
      $display("FAIL after_reset_open: got %h expected ff", o_w);
    end
    tick();
    bus.hold_n = 1'b0; bus.i = 8'h00;
    #1;
    tests_run++;
    if (o_w !== 8'hFF) begin
      tests_failed++;
      $display("FAIL after_reset_recapture: got %h expected ff", o_w);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    logic [7:0] got;
    m_held = 8'h00;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int n = 0; n < 300; n++) begin
      bus.i      = 8'($urandom_range(0, 255));
      bus.hold_n = ($urandom_range(0, 3) == 0);
      bus.oenb_n = ($urandom_range(0, 4) == 0);
      #1;
      // Occasional reset pulse landing between edges.
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        m_held = 8'h00;
        #1;
      end
      exp_q.push_back(model_out(reset, bus.hold_n, bus.oenb_n, bus.i, m_held));
      got = o_w;
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL random%0d: got %h expected %h (hold_n=%b oenb_n=%b i=%h)",
                 n, got, exp, bus.hold_n, bus.oenb_n, bus.i);
      end
      tick();
      reset = 1'b0;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b0;
    bus.i = 8'h00;
    bus.oenb_n = 1'b1;
    bus.hold_n = 1'b0;
    m_held = 8'h00;
    @(negedge clk);
    test_reset();
    test_enable_after_reset();
    test_transparent();
    test_hold();
    test_disable_while_holding();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
